// File: rtl/redtin_capture_ctl.sv
// redtin_capture_ctl: arms the Red Tin capture core, then streams its circular buffer oldest-first as 32-bit words
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_arm, cmd_abort          host single-cycle commands
//   la_reset                    one-cycle restart pulse to the core
//   la_done, la_start_addr      core stopped / oldest-sample address
//   la_read_addr, la_read_data  core read port (data arrives one cycle after address)
//   out_data/valid/ready/last   32-bit word stream, least-significant word of each sample first
//   busy, dump_done             not idle / one-cycle pulse after the final word is accepted
//
// Option: define REDTIN_HEADER_EN to emit {16'h5254, base} as a header word before the samples.
module redtin_capture_ctl #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_BITS = 9
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cmd_arm,
  input  logic                  cmd_abort,
  output logic                  la_reset,
  input  logic                  la_done,
  input  logic [ADDR_BITS-1:0]  la_start_addr,
  output logic [ADDR_BITS-1:0]  la_read_addr,
  input  logic [DATA_WIDTH-1:0] la_read_data,
  output logic [31:0]           out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last,
  output logic                  busy,
  output logic                  dump_done
);
  localparam int W = DATA_WIDTH / 32;
  localparam int KW = W > 1 ? $clog2(W) : 1;
  localparam logic [KW-1:0] KMAX = KW'(W - 1);
  typedef enum logic [2:0] {IDLE, RESET, ARMED, HDR, FETCH, LOAD, SEND} state_t;
  state_t state;
  logic [ADDR_BITS-1:0] i;
  logic [KW-1:0] k;
  logic [DATA_WIDTH-1:0] hold;
  logic abt_p, abt_rst, hs, stop, last_s;
  assign hs = out_valid & out_ready;
  // an abort seen while a word is offered only lands once that word is taken
  assign stop = abt_p | cmd_abort;
  assign last_s = &i;
  // la_read_addr doubles as base+i: latched from la_start_addr, then bumped per sample
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      la_reset <= 1'b0;
      la_read_addr <= '0;
      out_data <= '0;
      out_valid <= 1'b0;
      out_last <= 1'b0;
      busy <= 1'b0;
      dump_done <= 1'b0;
      i <= '0;
      k <= '0;
      hold <= '0;
      abt_p <= 1'b0;
      abt_rst <= 1'b0;
    end else begin
      la_reset <= 1'b0;
      dump_done <= 1'b0;
      case (state)
        IDLE: if (cmd_arm && !cmd_abort) begin
          state <= RESET;
          la_reset <= 1'b1;
          busy <= 1'b1;
          abt_rst <= 1'b0;
        end
        RESET: begin
          state <= abt_rst ? IDLE : ARMED;
          busy <= !abt_rst;
        end
        ARMED: if (cmd_abort) begin
          state <= RESET;
          la_reset <= 1'b1;
          abt_rst <= 1'b1;
        end else if (la_done) begin
          la_read_addr <= la_start_addr;
          i <= '0;
          abt_p <= 1'b0;
`ifdef REDTIN_HEADER_EN
          state <= HDR;
          out_valid <= 1'b1;
          out_data <= 32'h5254_0000 | 32'(la_start_addr);
`else
          state <= FETCH;
`endif
        end
        HDR: begin
          abt_p <= hs ? 1'b0 : stop;
          if (hs) begin
            out_valid <= 1'b0;
            state <= stop ? IDLE : FETCH;
            busy <= !stop;
          end
        end
        FETCH: begin
          state <= cmd_abort ? IDLE : LOAD;
          busy <= !cmd_abort;
        end
        LOAD: if (cmd_abort) begin
          state <= IDLE;
          busy <= 1'b0;
        end else begin
          state <= SEND;
          hold <= la_read_data;
          out_data <= la_read_data[31:0];
          out_valid <= 1'b1;
          out_last <= (KMAX == '0) && last_s;
          k <= '0;
          abt_p <= 1'b0;
        end
        SEND: begin
          abt_p <= hs ? 1'b0 : stop;
          if (hs) begin
            if (stop) begin
              state <= IDLE;
              out_valid <= 1'b0;
              out_last <= 1'b0;
              busy <= 1'b0;
            end else if (k != KMAX) begin
              k <= k + 1'b1;
              hold <= hold >> 32;
              out_data <= 32'(hold >> 32);
              out_last <= (k + 1'b1 == KMAX) && last_s;
            end else begin
              out_valid <= 1'b0;
              out_last <= 1'b0;
              state <= last_s ? IDLE : FETCH;
              busy <= !last_s;
              dump_done <= last_s;
              i <= i + 1'b1;
              la_read_addr <= last_s ? la_read_addr : la_read_addr + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_redtin_capture_ctl.sv
// tb_redtin_capture_ctl: randomized dump/abort/reset checks against a word-queue reference model
module tb_redtin_capture_ctl;
  localparam int DW = 128, AB = 9, DEPTH = 1 << AB, W = DW / 32;
`ifdef REDTIN_HEADER_EN
  localparam int HDR = 1;
`else
  localparam int HDR = 0;
`endif
  localparam int FULL = DEPTH * (W + 2) + 1 + HDR;
  typedef struct {
    logic [31:0] d;
    logic [AB-1:0] a;
  } ent_t;
  logic clk = 1'b0, rst_n = 1'b1, cmd_arm = 1'b0, cmd_abort = 1'b0, la_done = 1'b0, out_ready = 1'b0;
  logic [AB-1:0] la_start_addr = '0, cur_start = '0;
  logic la_reset, out_valid, out_last, busy, dump_done;
  logic [AB-1:0] la_read_addr;
  logic [DW-1:0] la_read_data = '0;
  logic [31:0] out_data;
  logic [DW-1:0] mem [DEPTH];
  ent_t exp_q[$];
  int n_chk = 0, n_err = 0, rdy_pct = 100;
  bit mon_on = 1'b1;
  redtin_capture_ctl dut (
    .clk(clk), .rst_n(rst_n), .cmd_arm(cmd_arm), .cmd_abort(cmd_abort),
    .la_reset(la_reset), .la_done(la_done), .la_start_addr(la_start_addr),
    .la_read_addr(la_read_addr), .la_read_data(la_read_data),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .busy(busy), .dump_done(dump_done)
  );
  always #5 clk = ~clk;
  always @(posedge clk) la_read_data <= mem[la_read_addr];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    bit stall = 1'b0, dd_exp = 1'b0, st_last = 1'b0;
    logic [31:0] st_data = '0;
    ent_t e;
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        stall = 1'b0;
        dd_exp = 1'b0;
      end else begin
        if (stall) begin
          chk("stall_valid", out_valid, 1);
          chk("stall_data", out_data, st_data);
          chk("stall_last", out_last, st_last);
        end
        if (dd_exp || dump_done) chk("dump_done", dump_done, dd_exp);
        dd_exp = 1'b0;
        out_ready = $urandom_range(99) < rdy_pct;
        stall = out_valid && !out_ready;
        st_data = out_data;
        st_last = out_last;
        if (out_valid && out_ready) begin
          chk("word_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("word", out_data, e.d);
            chk("addr", la_read_addr, e.a);
            chk("last", out_last, exp_q.size() == 0);
            dd_exp = exp_q.size() == 0;
          end
        end
      end
    end
  end
  task automatic start_dump(input logic [AB-1:0] start, input int pct, input bit pat);
    logic [AB-1:0] a;
    for (int x = 0; x < DEPTH; x++)
      for (int b = 0; b < DW / 8; b++)
        mem[x][8*b +: 8] = pat ? 8'(x + b) : 8'($urandom);
    exp_q.delete();
    if (HDR != 0) exp_q.push_back('{32'h5254_0000 | 32'(start), start});
    for (int s = 0; s < DEPTH; s++) begin
      a = AB'(start + s);
      for (int w = 0; w < W; w++) exp_q.push_back('{mem[a][32*w +: 32], a});
    end
    cur_start = start;
    rdy_pct = pct;
    @(negedge clk);
    cmd_arm = 1'b1;
    la_done = 1'b0;
    @(negedge clk);
    cmd_arm = 1'b0;
    chk("arm_reset_pulse", la_reset, 1);
    chk("arm_busy", busy, 1);
    @(negedge clk);
    chk("armed_reset_low", la_reset, 0);
    la_start_addr = start;
    la_done = 1'b1;
  endtask
  task automatic finish_dump(input bit arm_mid);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        chk("fetch_addr", la_read_addr, cur_start);
        chk("valid_n1", out_valid, HDR);
      end
      if (n == 3 && rdy_pct == 100) chk("valid_n3", out_valid, HDR == 0);
      if (n == 101) chk("arm_ignored", la_reset, 0);
      cmd_arm = arm_mid && n == 100;
    end while (!dump_done && n < 20000);
    chk("dump_done_seen", dump_done, 1);
    if (rdy_pct == 100) chk("cycles", n, FULL);
    chk("queue_drained", exp_q.size(), 0);
    chk("idle_after", busy, 0);
  endtask
  initial begin
    #2 rst_n = 1'b0;
    #1;
    chk("rst_la_reset", la_reset, 0);
    chk("rst_addr", la_read_addr, 0);
    chk("rst_data", out_data, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_dump_done", dump_done, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cmd_arm = 1'b1;
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_arm = 1'b0;
    cmd_abort = 1'b0;
    chk("arm_abort_no_reset", la_reset, 0);
    chk("arm_abort_busy", busy, 0);
    @(negedge clk);
    cmd_arm = 1'b1;
    la_done = 1'b0;
    @(negedge clk);
    cmd_arm = 1'b0;
    @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    chk("abort_armed_reset", la_reset, 1);
    chk("abort_armed_busy", busy, 1);
    @(negedge clk);
    chk("abort_armed_idle", busy, 0);
    chk("abort_armed_reset_low", la_reset, 0);
    start_dump('0, 100, 1'b1);
    finish_dump(1'b0);
    start_dump(AB'(9'h1F0), 100, 1'b0);
    finish_dump(1'b0);
    start_dump(AB'(9'h123), 50, 1'b1);
    finish_dump(1'b1);
    start_dump(AB'($urandom), 0, 1'b0);
    for (int t = 0; t < 20 && !out_valid; t++) @(negedge clk);
    chk("stalled_valid", out_valid, 1);
    repeat (2) @(negedge clk);
    cmd_abort = 1'b1;
    @(negedge clk);
    cmd_abort = 1'b0;
    repeat (3) @(negedge clk);
    chk("abort_pending_valid", out_valid, 1);
    rdy_pct = 100;
    repeat (3) @(negedge clk);
    chk("abort_send_valid", out_valid, 0);
    chk("abort_send_busy", busy, 0);
    chk("abort_send_no_done", dump_done, 0);
    exp_q.delete();
    start_dump(AB'($urandom), 100, 1'b0);
    repeat (40) @(negedge clk);
    mon_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_busy", busy, 0);
    chk("async_addr", la_read_addr, 0);
    chk("async_data", out_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    la_done = 1'b0;
    mon_on = 1'b1;
    start_dump(AB'($urandom), 70, 1'b0);
    finish_dump(1'b0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule

// File: doc/redtin_capture_ctl.md
# redtin_capture_ctl

Sequencing controller for the Red Tin capture core. Arms the core, waits for its `done`, then walks the 512-entry circular capture buffer in chronological order, oldest sample first. Each sample is serialized into 32-bit words on a valid/ready stream for the host-side transport. Sits between the host command interface and the capture core's read port.

## Interface
Parameters:
- `DATA_WIDTH`, 128: capture sample width; must be a multiple of 32. W = DATA_WIDTH/32 words per sample.
- `ADDR_BITS`, 9: capture buffer address width; DEPTH = 2^ADDR_BITS.

Ports:
- `clk`  in  1: single clock, shared with the capture core.
- `rst_n`  in  1: asynchronous, active-low reset.
- `cmd_arm`  in  1: single-cycle request to start a capture.
- `cmd_abort`  in  1: single-cycle request to cancel.
- `la_reset`  out  1: one-cycle restart pulse to the core.
- `la_done`  in  1: core has stopped capturing.
- `la_start_addr`  in  ADDR_BITS: oldest-sample address exported by the core.
- `la_read_addr`  out  ADDR_BITS: core read address.
- `la_read_data`  in  DATA_WIDTH: core read data, registered inside the core (1-cycle latency).
- `out_data`  out  32: stream word.
- `out_valid`  out  1: stream word valid.
- `out_ready`  in  1: stream sink ready.
- `out_last`  out  1: final word of the dump.
- `busy`  out  1: high in every state except IDLE.
- `dump_done`  out  1: one-cycle pulse after the final word is accepted.

## Operation
- States: IDLE, RESET, ARMED, HDR (only with the configuration macro), FETCH, LOAD, SEND.
- IDLE: `cmd_arm` -> RESET. Arm is ignored in every other state. If `cmd_arm` and `cmd_abort` arrive together in IDLE, abort wins and the block stays in IDLE.
- RESET: `la_reset`=1 for exactly one cycle, then ARMED.
- ARMED: wait for `la_done`=1. On that cycle, latch `la_start_addr` into `base`, clear sample index `i`, and go to HDR or FETCH. `cmd_abort` -> RESET, then IDLE; the core is left re-armed and ignored.
- FETCH: drive `la_read_addr` = (`base` + `i`) mod DEPTH; wrap-around is natural ADDR_BITS truncation. Next state is LOAD.
- LOAD: `la_read_data` is valid; capture it into the hold register, clear word counter `k`, go to SEND.
- SEND: `out_data` = hold[32k+31:32k], least-significant word first, `out_valid`=1. On handshake (`out_valid`&`out_ready`):
  - k<W-1: k++.
  - k=W-1 and i<DEPTH-1: i++, go to FETCH.
  - k=W-1 and i=DEPTH-1: pulse `dump_done`, go to IDLE.
- `out_last` = 1 only during SEND with i=DEPTH-1 and k=W-1.
- `la_read_addr` holds its value through LOAD and SEND.
- `cmd_abort` in FETCH or LOAD -> IDLE immediately. In SEND or HDR it is registered as pending and takes effect right after the current word's handshake. `out_valid` is never withdrawn without a handshake. `dump_done` is not pulsed on abort.

## Timing
- Reset values: `la_reset`=0, `la_read_addr`=0, `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `dump_done`=0, state IDLE.
- Cycle after `cmd_arm` sampled: `la_reset`=1. The cycle after that: state is ARMED.
- `la_done` sampled in cycle N: FETCH in N+1 (N+2 with the header), LOAD in N+2, first `out_valid` in N+3.
- With `out_ready` held at 1: W+2 cycles per sample. A full dump is DEPTH·(W+2) cycles (3072 at default parameters), plus 1 cycle with the header.
- Data and control are stable while `out_valid`=1 and `out_ready`=0.
- `rst_n` low at any time: all outputs take their reset values asynchronously and the dump is discarded.

## Configuration
- `REDTIN_HEADER_EN` defined: the HDR state emits one word {16'h5254, 7'b0, base[8:0]} before the first sample, with the same handshake rules. `out_last` is unaffected.
- Not defined: no HDR state; the first stream word is sample 0, word 0.

## Test plan
- Basic dump: arm, drive `la_done` with `la_start_addr`=0, `out_ready`=1 -> 2048 words emitted, reading addresses 0..511 in order; `out_last` on word 2047; `dump_done` one cycle after its handshake.
- Wrap: `la_start_addr`=0x1F0 -> `la_read_addr` sequence 0x1F0..0x1FF, 0x000..0x1EF; the last sample is read from address 0x1EF.
- Backpressure: toggle `out_ready` randomly -> no word lost or duplicated; `out_data` stable while stalled; word order LSW first (0x…03020100 pattern checks).
- Abort: abort in ARMED -> `la_reset` pulse, then IDLE. Abort in SEND while stalled -> current word completes on `out_ready`, then IDLE, no `dump_done`.
- Arm and abort in the same IDLE cycle -> no `la_reset`, `busy` stays 0. Arm while busy -> ignored.
- Header (`REDTIN_HEADER_EN`): `la_start_addr`=0x123 -> first word 0x52540123, then 2048 sample words. Async `rst_n` mid-dump -> `out_valid`=0 immediately.
